// File: rtl/zxuno_regs_pkg.sv
// Shared constants for ZXUNO register peripherals: default register
// addresses and the entry numbers of the board-capability bank.
package zxuno_regs_pkg;

    localparam logic [7:0] ZXUNO_IDX_ADDR  = 8'hF8;
    localparam logic [7:0] ZXUNO_DATA_ADDR = 8'hF9;

    // Entry numbers inside board_caps_bank.
    localparam int ENT_MODEL     = 0;
    localparam int ENT_MEMREPORT = 1;
    localparam int ENT_VIDEO     = 2;
    localparam int ENT_SYSCFG    = 3;

endpackage

// File: rtl/board_caps_bank_if.sv
// ZXUNO register-bus slice seen by one register peripheral.
//
// Handshake: zxuno_regrd / zxuno_regwr are level strobes qualified by
// zxuno_addr. An access begins on the rising edge of a strobe and ends
// on its falling edge; there is no ready/backpressure, the peripheral
// always accepts. dout is valid whenever oe is high.
interface board_caps_bank_if;

    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       zxuno_regwr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;

    modport master (
        output zxuno_addr, zxuno_regrd, zxuno_regwr, din,
        input  dout, oe
    );

    modport slave (
        input  zxuno_addr, zxuno_regrd, zxuno_regwr, din,
        output dout, oe
    );

endinterface

// File: rtl/zxuno_strobe_edge.sv
// Registers a level strobe and reports its rising and falling edges as
// single-cycle pulses relative to the registered history.
module zxuno_strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic rise,
    output logic fall
);

    logic level_d;
    logic level_q;

    // Next history value is simply the current strobe level.
    always_comb begin
        level_d = strobe;
    end

    // Strobe history; cleared by reset so a held strobe re-triggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign rise = strobe & ~level_q;
    assign fall = ~strobe & level_q;

endmodule

// File: rtl/board_caps_bank.sv
// Bank of board-capability / configuration bytes behind an index
// register and an auto-incrementing data window. Read-only entries are
// hardwired inputs; writable entries change only in boot mode and only
// until the sticky lock is set.
module board_caps_bank
    import zxuno_regs_pkg::*;
#(
    parameter int                  NREGS      = 8,
    parameter logic [7:0]          IDX_ADDR   = ZXUNO_IDX_ADDR,
    parameter logic [7:0]          DATA_ADDR  = ZXUNO_DATA_ADDR,
    parameter logic [NREGS-1:0]    WR_MASK    = '0,
    parameter logic [NREGS*8-1:0]  RST_VALUES = '0
) (
    input  logic                 clk,
    input  logic                 poweron_rst_n,
    input  logic                 in_boot_mode,
    board_caps_bank_if.slave     bus,
    input  logic [NREGS*8-1:0]   ro_values,
    output logic [NREGS*8-1:0]   cfg_values,
    output logic                 locked
);

    localparam int              IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    logic rd_rise, rd_fall;
    logic wr_rise, wr_fall;

    zxuno_strobe_edge u_rd_edge (
        .clk    (clk),
        .rst_n  (poweron_rst_n),
        .strobe (bus.zxuno_regrd),
        .rise   (rd_rise),
        .fall   (rd_fall)
    );

    zxuno_strobe_edge u_wr_edge (
        .clk    (clk),
        .rst_n  (poweron_rst_n),
        .strobe (bus.zxuno_regwr),
        .rise   (wr_rise),
        .fall   (wr_fall)
    );

    logic [IDX_W-1:0] idx_d, idx_q;
    logic             locked_d, locked_q;
    logic             pend_inc_d, pend_inc_q;
    // Remembers which strobe opened the pending data access, so only the
    // falling edge of that same strobe triggers the increment.
    logic             pend_wr_d, pend_wr_q;

    logic sel_idx, sel_data;
    logic rd_start;
    logic idx_wr, data_wr, data_acc;
    logic din_idx_ok;
    logic inc_now;
    logic ent_we;

    // Access decode: a write start takes priority over a simultaneous read start.
    always_comb begin
        sel_idx    = (bus.zxuno_addr == IDX_ADDR);
        sel_data   = (bus.zxuno_addr == DATA_ADDR);
        rd_start   = rd_rise & ~wr_rise;
        idx_wr     = wr_rise & sel_idx;
        data_wr    = wr_rise & sel_data;
        data_acc   = data_wr | (rd_start & sel_data);
        din_idx_ok = ({1'b0, bus.din[6:0]} < 8'(NREGS));
        inc_now    = pend_inc_q & (pend_wr_q ? wr_fall : rd_fall);
        ent_we     = data_wr & in_boot_mode & ~locked_q;
    end

    // Index, lock and pending-increment next state.
    always_comb begin
        idx_d      = idx_q;
        locked_d   = locked_q;
        pend_inc_d = pend_inc_q;
        pend_wr_d  = pend_wr_q;
        if (inc_now) begin
            idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            pend_inc_d = 1'b0;
        end
        if (idx_wr) begin
            if (bus.din[7]) begin
                locked_d = 1'b1;
            end
            if (din_idx_ok) begin
                idx_d = bus.din[IDX_W-1:0];
            end
        end
        if (data_acc) begin
            pend_inc_d = 1'b1;
            pend_wr_d  = data_wr;
        end
    end

    // Index/lock/pending registers.
    always_ff @(posedge clk or negedge poweron_rst_n) begin
        if (!poweron_rst_n) begin
            idx_q      <= '0;
            locked_q   <= 1'b0;
            pend_inc_q <= 1'b0;
            pend_wr_q  <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            locked_q   <= locked_d;
            pend_inc_q <= pend_inc_d;
            pend_wr_q  <= pend_wr_d;
        end
    end

    assign locked = locked_q;

    logic [7:0] ent [NREGS];

    for (genvar i = 0; i < NREGS; i++) begin : g_ent
        if (WR_MASK[i]) begin : g_rw
            logic [7:0] ent_d, ent_q;
            // The board value for a writable entry is not used.
            logic       unused_ro;

            // Capture din when this entry is the target of an accepted write.
            always_comb begin
                ent_d = ent_q;
                if (ent_we && (idx_q == IDX_W'(i))) begin
                    ent_d = bus.din;
                end
            end

            // Writable entry storage, reset to its image byte.
            always_ff @(posedge clk or negedge poweron_rst_n) begin
                if (!poweron_rst_n) begin
                    ent_q <= RST_VALUES[8*i +: 8];
                end else begin
                    ent_q <= ent_d;
                end
            end

            assign ent[i]    = ent_q;
            assign unused_ro = ^ro_values[8*i +: 8];
        end else begin : g_ro
            assign ent[i] = ro_values[8*i +: 8];
        end
        assign cfg_values[8*i +: 8] = ent[i];
    end

    logic [7:0] data_rd;

    // Read mux: index/lock view, selected entry, or zero when not addressed.
    always_comb begin
        data_rd = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                data_rd = ent[i];
            end
        end
        if (sel_idx) begin
            bus.dout = {locked_q, 7'(idx_q)};
        end else if (sel_data) begin
            bus.dout = data_rd;
        end else begin
            bus.dout = 8'h00;
        end
        bus.oe = (sel_idx | sel_data) & bus.zxuno_regrd;
    end

endmodule

// File: tb/tb_board_caps_bank.sv
// Bench for board_caps_bank: an 8-entry bank (A) and a 5-entry bank (B)
// on a shared clock/reset, driven through access tasks against a small
// behavioural model, with read data checked through an expected queue.
module tb_board_caps_bank;
    import zxuno_regs_pkg::*;

    localparam logic [63:0] RST_A  = 64'h1716151413121110;
    localparam logic [63:0] RO_A   = 64'hE7E6E5E4E3E2E109;
    localparam logic [7:0]  MASK_A = 8'hFE;
    localparam logic [39:0] RST_B  = 40'h2423222120;
    localparam logic [39:0] RO_B   = 40'hC4C3C2C155;
    localparam logic [4:0]  MASK_B = 5'h1E;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic boot = 1'b1;
    always #5 clk = ~clk;

    board_caps_bank_if bus_a ();
    board_caps_bank_if bus_b ();

    logic [63:0] cfg_a;
    logic [39:0] cfg_b;
    logic        locked_a, locked_b;

    board_caps_bank #(
        .NREGS(8), .WR_MASK(MASK_A), .RST_VALUES(RST_A)
    ) dut_a (
        .clk(clk), .poweron_rst_n(rst_n), .in_boot_mode(boot), .bus(bus_a),
        .ro_values(RO_A), .cfg_values(cfg_a), .locked(locked_a)
    );

    board_caps_bank #(
        .NREGS(5), .WR_MASK(MASK_B), .RST_VALUES(RST_B)
    ) dut_b (
        .clk(clk), .poweron_rst_n(rst_n), .in_boot_mode(boot), .bus(bus_b),
        .ro_values(RO_B), .cfg_values(cfg_b), .locked(locked_b)
    );

    // ---------------- model / scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          m_n[2];
    logic [7:0]  m_ent[2][8];
    logic [6:0]  m_idx[2];
    logic        m_lock[2];
    logic [7:0]  m_mask[2];
    logic [63:0] rst_img[2];
    logic [63:0] ro_img[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_idx[b]  = '0;
            m_lock[b] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_ent[b][i] = m_mask[b][i] ? rst_img[b][8*i +: 8] : ro_img[b][8*i +: 8];
            end
        end
    endtask

    function automatic logic [63:0] model_cfg(input int b);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < m_n[b]; i++) v[8*i +: 8] = m_ent[b][i];
        return v;
    endfunction

    function automatic logic [6:0] model_next(input int b);
        return (int'(m_idx[b]) == m_n[b] - 1) ? 7'd0 : m_idx[b] + 7'd1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_bus(input int b, input logic [7:0] a, input logic r, input logic w,
                           input logic [7:0] d);
        if (b == 0) begin
            bus_a.zxuno_addr = a; bus_a.zxuno_regrd = r; bus_a.zxuno_regwr = w; bus_a.din = d;
        end else begin
            bus_b.zxuno_addr = a; bus_b.zxuno_regrd = r; bus_b.zxuno_regwr = w; bus_b.din = d;
        end
    endtask

    function automatic logic [7:0] get_dout(input int b);
        return (b == 0) ? bus_a.dout : bus_b.dout;
    endfunction

    function automatic logic get_oe(input int b);
        return (b == 0) ? bus_a.oe : bus_b.oe;
    endfunction

    task automatic chk_state(input int b, input string tag);
        chk({tag, "_cfg"}, (b == 0) ? cfg_a : {24'h0, cfg_b}, model_cfg(b));
        chk({tag, "_lock"}, {63'h0, (b == 0) ? locked_a : locked_b}, {63'h0, m_lock[b]});
    endtask

    // Read access held for cyc cycles; data sampled on the first and last cycle.
    task automatic rd_acc(input int b, input logic [7:0] a, input int cyc, input string tag);
        logic [7:0] e;
        if (a == ZXUNO_IDX_ADDR)       e = {m_lock[b], m_idx[b]};
        else if (a == ZXUNO_DATA_ADDR) e = m_ent[b][m_idx[b]];
        else                           e = 8'h00;
        exp_q.push_back(e);
        if (cyc > 1) exp_q.push_back(e);
        @(negedge clk);
        set_bus(b, a, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < cyc; k++) begin
            @(negedge clk);
            if (k == 0 || k == cyc - 1) begin
                chk(tag, {56'h0, get_dout(b)}, {56'h0, exp_q.pop_front()});
                chk({tag, "_oe"}, {63'h0, get_oe(b)}, 64'h1);
            end
        end
        set_bus(b, a, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        if (a == ZXUNO_DATA_ADDR) m_idx[b] = model_next(b);
    endtask

    // Write access (optionally with a simultaneous read strobe).
    task automatic wr_acc(input int b, input logic [7:0] a, input logic [7:0] d, input int cyc,
                          input logic with_rd);
        @(negedge clk);
        set_bus(b, a, with_rd, 1'b1, d);
        repeat (cyc) @(negedge clk);
        set_bus(b, a, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        if (a == ZXUNO_IDX_ADDR) begin
            if (d[7]) m_lock[b] = 1'b1;
            if (int'(d[6:0]) < m_n[b]) m_idx[b] = d[6:0];
        end else if (a == ZXUNO_DATA_ADDR) begin
            if (boot && !m_lock[b] && m_mask[b][m_idx[b]]) m_ent[b][m_idx[b]] = d;
            m_idx[b] = model_next(b);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_n[0] = 8;        m_n[1] = 5;
        m_mask[0] = MASK_A; m_mask[1] = {3'b000, MASK_B};
        rst_img[0] = RST_A; rst_img[1] = {24'h0, RST_B};
        ro_img[0]  = RO_A;  ro_img[1]  = {24'h0, RO_B};
        model_reset();
        set_bus(0, ZXUNO_DATA_ADDR, 1'b0, 1'b0, 8'h00);
        set_bus(1, 8'h00, 1'b0, 1'b0, 8'h00);

        // Reset state.
        repeat (3) @(negedge clk);
        chk_state(0, "rst_a");
        chk_state(1, "rst_b");
        chk("rst_dout_data", {56'h0, bus_a.dout}, 64'h09);
        chk("rst_oe", {63'h0, bus_a.oe}, 64'h0);
        rst_n = 1'b1;

        // Sequential reads through the data window.
        rd_acc(0, ZXUNO_DATA_ADDR, 4, "rd_ent0");
        rd_acc(0, ZXUNO_DATA_ADDR, 4, "rd_ent1");
        rd_acc(0, ZXUNO_DATA_ADDR, 4, "rd_ent2");
        rd_acc(0, ZXUNO_IDX_ADDR, 1, "rd_idx3");
        @(negedge clk);
        set_bus(0, 8'h00, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        chk("unsel_oe", {63'h0, bus_a.oe}, 64'h0);
        chk("unsel_dout", {56'h0, bus_a.dout}, 64'h0);
        set_bus(0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Boot-mode writes.
        wr_acc(0, ZXUNO_IDX_ADDR, 8'(ENT_MEMREPORT), 1, 1'b0);
        wr_acc(0, ZXUNO_DATA_ADDR, 8'hA5, 6, 1'b0);
        chk_state(0, "wr_ent1");
        rd_acc(0, ZXUNO_IDX_ADDR, 1, "idx_after_wr");
        wr_acc(0, ZXUNO_IDX_ADDR, 8'(ENT_MODEL), 1, 1'b0);
        wr_acc(0, ZXUNO_DATA_ADDR, 8'h5A, 2, 1'b0);
        chk_state(0, "wr_ro_ignored");
        rd_acc(0, ZXUNO_IDX_ADDR, 1, "idx_after_ro_wr");
        rd_acc(0, ZXUNO_DATA_ADDR, 2, "rd_back_ent1");

        // Outside boot mode: writes discarded; out-of-range index ignored.
        boot = 1'b0;
        wr_acc(0, ZXUNO_IDX_ADDR, 8'(ENT_SYSCFG), 1, 1'b0);
        wr_acc(0, ZXUNO_DATA_ADDR, 8'h66, 2, 1'b0);
        chk_state(0, "noboot_wr");
        wr_acc(0, ZXUNO_IDX_ADDR, 8'h7F, 1, 1'b0);
        rd_acc(0, ZXUNO_IDX_ADDR, 1, "idx_oor");
        boot = 1'b1;

        // Lock.
        wr_acc(0, ZXUNO_IDX_ADDR, 8'h81, 1, 1'b0);
        chk_state(0, "lock_set");
        wr_acc(0, ZXUNO_DATA_ADDR, 8'h3C, 3, 1'b0);
        chk_state(0, "locked_wr");
        wr_acc(0, ZXUNO_IDX_ADDR, 8'h01, 1, 1'b0);
        rd_acc(0, ZXUNO_IDX_ADDR, 1, "idx_locked");

        // Both strobes rise together at the data window: one increment.
        wr_acc(0, ZXUNO_DATA_ADDR, 8'h77, 2, 1'b1);
        rd_acc(0, ZXUNO_IDX_ADDR, 1, "idx_both");

        // Wrap on the 8-entry and 5-entry banks.
        wr_acc(0, ZXUNO_IDX_ADDR, 8'h07, 1, 1'b0);
        rd_acc(0, ZXUNO_DATA_ADDR, 2, "rd_ent7");
        rd_acc(0, ZXUNO_IDX_ADDR, 1, "idx_wrap8");
        wr_acc(1, ZXUNO_IDX_ADDR, 8'h04, 1, 1'b0);
        rd_acc(1, ZXUNO_DATA_ADDR, 2, "rd_b_ent4");
        rd_acc(1, ZXUNO_IDX_ADDR, 1, "idx_wrap5");
        wr_acc(1, ZXUNO_DATA_ADDR, 8'hB1, 1, 1'b0);
        chk_state(1, "wr_b");

        // Reset in the middle of a data read: pending increment discarded.
        @(negedge clk);
        set_bus(0, ZXUNO_DATA_ADDR, 1'b1, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_state(0, "midrst_a");
        chk_state(1, "midrst_b");
        @(negedge clk);
        set_bus(0, ZXUNO_DATA_ADDR, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rd_acc(0, ZXUNO_IDX_ADDR, 1, "idx_no_inc");

        // Write strobe held through reset counts as a new access.
        @(negedge clk);
        set_bus(0, ZXUNO_IDX_ADDR, 1'b0, 1'b1, 8'h05);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        set_bus(0, ZXUNO_IDX_ADDR, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        m_idx[0] = 7'd5;
        rd_acc(0, ZXUNO_IDX_ADDR, 1, "idx_held_wr");
        rd_acc(0, ZXUNO_DATA_ADDR, 2, "rd_ent5_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
